// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: drives per-destination bus selectors and load strobes from a small request FIFO.
// Define BUS_XFER_OVERLAP_EN to let disjoint back-to-back transfers skip the DRIVE cycle.
module bus_xfer_ctrl #(
  parameter int NUM_DEST = 11,
  parameter int SEL_W    = 4,
  parameter int DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [SEL_W-1:0]          req_src,
  input  logic [NUM_DEST-1:0]       req_dest,
  input  logic                      req_last,
  input  logic                      flush,
  output logic [NUM_DEST*SEL_W-1:0] sel_bus,
  output logic [NUM_DEST-1:0]       load_en,
  output logic                      done,
  output logic                      busy,
  output logic                      err
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = SEL_W + NUM_DEST + 1;
  localparam logic [SEL_W-1:0] SRC_MAX = SEL_W'(11);
`ifdef BUS_XFER_OVERLAP_EN
  localparam bit OVL_EN = 1'b1;
`else
  localparam bit OVL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DRIVE, LOAD} state_t;

  logic [EW-1:0]             fifo_q [DEPTH];
  logic [AW:0]               wr_ptr_q, rd_ptr_q, fill_cnt, nxt_ptr;
  logic                      empty, full, push, pop;
  logic [SEL_W-1:0]          head_src;
  logic [NUM_DEST-1:0]       head_dest;
  logic                      head_last;
  logic [EW-1:0]             nxt_entry;
  logic                      nxt_unused;
  logic                      head_ok, nxt_ok;

  state_t                    state_q;
  logic [SEL_W-1:0]          cur_src_q;
  logic [NUM_DEST-1:0]       cur_dest_q;
  logic                      cur_last_q;
  logic [NUM_DEST*SEL_W-1:0] sel_q;
  logic [NUM_DEST-1:0]       load_q;
  logic                      done_q, err_q, ovl_q;

  function automatic logic legal(input logic [SEL_W-1:0] src);
    return src <= SRC_MAX;
  endfunction

  function automatic logic [NUM_DEST*SEL_W-1:0] build_sel(input logic [SEL_W-1:0] src,
                                                          input logic [NUM_DEST-1:0] dest);
    logic [NUM_DEST*SEL_W-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_DEST; i++)
      if (dest[i] && legal(src)) s[i*SEL_W +: SEL_W] = src;
    return s;
  endfunction

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fill_cnt  = wr_ptr_q - rd_ptr_q;
  assign req_ready = !full && !flush;
  assign push      = req_valid && req_ready;
  assign pop       = !flush && !empty && (state_q == IDLE || state_q == LOAD);
  assign {head_src, head_dest, head_last} = fifo_q[rd_ptr_q[AW-1:0]];

  // Overlap candidates: the head while a transfer moves into LOAD, and the entry behind it.
  assign nxt_ptr    = rd_ptr_q + 1'b1;
  assign nxt_entry  = fifo_q[nxt_ptr[AW-1:0]];
  assign nxt_unused = nxt_entry[0];
  assign head_ok    = OVL_EN && !empty && legal(head_src) && ((head_dest & cur_dest_q) == '0);
  assign nxt_ok     = OVL_EN && (fill_cnt >= (AW+1)'(2)) && legal(nxt_entry[EW-1 -: SEL_W])
                      && ((nxt_entry[NUM_DEST:1] & head_dest) == '0);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= {req_src, req_dest, req_last};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      rd_ptr_q <= wr_ptr_q;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cur_src_q  <= '0;
      cur_dest_q <= '0;
      cur_last_q <= 1'b0;
      sel_q      <= '0;
      load_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovl_q      <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      sel_q   <= '0;
      load_q  <= '0;
      done_q  <= 1'b0;
      ovl_q   <= 1'b0;
    end else begin
      load_q <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q    <= DRIVE;
            cur_src_q  <= head_src;
            cur_dest_q <= head_dest;
            cur_last_q <= head_last;
            sel_q      <= build_sel(head_src, head_dest);
            err_q      <= err_q | !legal(head_src);
          end
        end
        DRIVE: begin
          state_q <= LOAD;
          load_q  <= legal(cur_src_q) ? cur_dest_q : '0;
          done_q  <= cur_last_q;
          ovl_q   <= head_ok;
          if (head_ok) sel_q <= sel_q | build_sel(head_src, head_dest);
        end
        LOAD: begin
          if (pop && ovl_q) begin
            // Head selectors were already on the bus this cycle, so it can load next.
            state_q    <= LOAD;
            cur_src_q  <= head_src;
            cur_dest_q <= head_dest;
            cur_last_q <= head_last;
            load_q     <= head_dest;
            done_q     <= head_last;
            ovl_q      <= nxt_ok;
            sel_q      <= build_sel(head_src, head_dest)
                          | (nxt_ok ? build_sel(nxt_entry[EW-1 -: SEL_W], nxt_entry[NUM_DEST:1]) : '0);
          end else if (pop) begin
            state_q    <= DRIVE;
            cur_src_q  <= head_src;
            cur_dest_q <= head_dest;
            cur_last_q <= head_last;
            sel_q      <= build_sel(head_src, head_dest);
            err_q      <= err_q | !legal(head_src);
            ovl_q      <= 1'b0;
          end else begin
            state_q <= IDLE;
            sel_q   <= '0;
            ovl_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel_bus = sel_q;
  assign load_en = load_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE) || !empty;

endmodule
